seven_seg_scan_ctrl: RTL and testbench

//  Parametrised multi-digit seven-segment display controller. Converts a binary value to

---
 rtl/seven_seg_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Multi-digit common-anode seven-segment scanner. A binary value is shown either
// as hex nibbles (loaded directly) or as decimal via a sequential double-dabble
// converter, one shift per clock. The digits are time-multiplexed, one slot per tick.
//
// Converter FSM
//   state  | meaning
//   S_IDLE | waiting for value_valid; hex loads complete here in one edge
//   S_CONV | double-dabble running, busy high, one iteration per clock
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int VALUE_W    = 32,
  parameter int TICK_DIV   = 100000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  value_valid,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  enable,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode,
  output logic                  dp,
  output logic                  busy,
  output logic                  overflow
);

  localparam int DW = NUM_DIGITS * 4;
  localparam int XW = (VALUE_W > DW) ? VALUE_W : DW;
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(VALUE_W + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] ITER_LAST = CW'(VALUE_W - 1);
  localparam logic [XW-1:0] LOW_MASK  = XW'({DW{1'b1}});

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t               state;
  logic [DW-1:0]        display;
  logic [DW-1:0]        bcd_reg;
  logic [DW-1:0]        bcd_adj;
  logic [DW-1:0]        bcd_shifted;
  logic [VALUE_W-1:0]   shift_reg;
  logic [CW-1:0]        iter_cnt;
  logic                 sticky;
  logic [XW-1:0]        value_ext;

  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [IW-1:0]        scan_idx;
  logic [IW-1:0]        idx_next;
  logic [3:0]           digit_next;
  logic                 upper_zero;
  logic                 blank_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign value_ext = XW'(value);
  assign tick      = (tick_cnt == TICK_LAST);

  // Double-dabble step: +3 on every digit >= 5, then shift the next value bit in.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_reg[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_reg[d*4 +: 4] + 4'd3;
    end
    bcd_shifted = {bcd_adj[DW-2:0], shift_reg[VALUE_W-1]};
  end

  // Converter FSM; display is only written once a result is complete.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      display   <= '0;
      bcd_reg   <= '0;
      shift_reg <= '0;
      iter_cnt  <= '0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (value_valid) begin
            if (hex_mode) begin
              display  <= value_ext[DW-1:0];
              overflow <= |(value_ext & ~LOW_MASK);
            end else begin
              shift_reg <= value;
              bcd_reg   <= '0;
              sticky    <= 1'b0;
              iter_cnt  <= ITER_LAST;
              busy      <= 1'b1;
              state     <= S_CONV;
            end
          end
        end
        S_CONV: begin
          bcd_reg   <= bcd_shifted;
          shift_reg <= {shift_reg[VALUE_W-2:0], 1'b0};
          if (iter_cnt == '0) begin
            display  <= bcd_shifted;
            overflow <= sticky | bcd_adj[DW-1];
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            iter_cnt <= iter_cnt - 1'b1;
            sticky   <= sticky | bcd_adj[DW-1];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Next slot index and its blanking decision, evaluated against live inputs.
  always_comb begin
    idx_next   = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    digit_next = display[{idx_next, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (d >= int'(idx_next) && display[d*4 +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank_next = !enable || (blank_lz && (idx_next != '0) && upper_zero);
  end

  // Slot timer: free-running 0..TICK_DIV-1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Advance the scan and register the pin values for the new slot on each tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx <= '0;
      anode    <= '1;
      cathode  <= 7'h7F;
      dp       <= 1'b1;
    end else if (tick) begin
      scan_idx <= idx_next;
      if (blank_next) begin
        anode   <= '1;
        cathode <= 7'h7F;
        dp      <= 1'b1;
      end else begin
        anode   <= ~(NUM_DIGITS'(1) << idx_next);
        cathode <= seg_decode(digit_next);
        dp      <= ~dp_mask[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with 4 digits, 16-bit value, 4-cycle slots.
// Expected pin values come from decimal/hex arithmetic on the loaded value and
// from the cycle count since reset release (tick every 4th edge).
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;
  localparam int W = 16;
  localparam int T = 4;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] value = '0;
  logic         value_valid = 1'b0;
  logic         hex_mode = 1'b0;
  logic         blank_lz = 1'b1;
  logic [N-1:0] dp_mask = '0;
  logic         enable = 1'b1;
  logic [N-1:0] anode;
  logic [6:0]   cathode;
  logic         dp;
  logic         busy;
  logic         overflow;

  int cyc = 0;
  int passes = 0;
  int fails = 0;
  int total = 0;
  int md [N];
  int ovf_m = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .VALUE_W(W), .TICK_DIV(T)) dut (
    .clock(clock), .reset_n(reset_n), .value(value), .value_valid(value_valid),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .dp_mask(dp_mask), .enable(enable),
    .anode(anode), .cathode(cathode), .dp(dp), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic set_dec(input int v);
    int x;
    x = v % 10000;
    for (int i = 0; i < N; i++) begin
      md[i] = x % 10;
      x = x / 10;
    end
    ovf_m = (v >= 10000) ? 1 : 0;
  endtask

  task automatic set_hex(input int v);
    for (int i = 0; i < N; i++) md[i] = (v >> (4 * i)) & 15;
    ovf_m = 0;
  endtask

  task automatic start(input int v, input logic h);
    value = W'(v);
    hex_mode = h;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      step();
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Waits for the tick that selects slot k, then checks the registered pins.
  task automatic check_slot(input int k);
    int g;
    bit hit;
    bit allz;
    bit blank;
    logic [3:0] ea;
    logic [6:0] ec;
    logic ed;
    g = 0;
    hit = 1'b0;
    while (!hit && g < 40) begin
      step();
      g++;
      if (cyc % T == 0 && (cyc / T) % N == k) hit = 1'b1;
    end
    chk($sformatf("slot%0d_wait", k), 32'(hit), 32'd1);
    allz = 1'b1;
    for (int i = k; i < N; i++) if (md[i] != 0) allz = 1'b0;
    blank = !enable || (blank_lz && k > 0 && allz);
    ea = 4'hF;
    ec = 7'h7F;
    ed = 1'b1;
    if (!blank) begin
      ea[k] = 1'b0;
      ec = SEG[md[k]];
      ed = ~dp_mask[k];
    end
    chk($sformatf("anode_s%0d", k), 32'(anode), 32'(ea));
    chk($sformatf("cathode_s%0d", k), 32'(cathode), 32'(ec));
    chk($sformatf("dp_s%0d", k), 32'(dp), 32'(ed));
  endtask

  task automatic check_scan();
    check_slot(1);
    check_slot(2);
    check_slot(3);
    check_slot(0);
  endtask

  initial begin
    int n;
    int v;
    logic h;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_cathode", 32'(cathode), 32'h7F);
    chk("rst_busy", 32'(busy), 32'd0);
    release_reset();

    // Reset in the middle of a decimal conversion.
    blank_lz = 1'b1;
    start(999, 1'b0);
    chk("conv_started", 32'(busy), 32'd1);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("midrst_anode", 32'(anode), 32'hF);
    chk("midrst_cathode", 32'(cathode), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    release_reset();
    set_dec(0);
    check_scan();

    // 1234 decimal.
    blank_lz = 1'b0;
    dp_mask = 4'b0000;
    start(1234, 1'b0);
    wait_idle(n);
    chk("busy_len_1234", 32'(n), 32'd16);
    set_dec(1234);
    chk("ovf_1234", 32'(overflow), 32'(ovf_m));
    check_scan();

    // 54321 wraps to 4321 with overflow.
    start(54321, 1'b0);
    wait_idle(n);
    chk("busy_len_54321", 32'(n), 32'd16);
    set_dec(54321);
    chk("ovf_54321", 32'(overflow), 32'(ovf_m));
    check_scan();

    // 7 with and without leading-zero blanking.
    blank_lz = 1'b1;
    start(7, 1'b0);
    wait_idle(n);
    set_dec(7);
    chk("ovf_7", 32'(overflow), 32'(ovf_m));
    check_scan();
    blank_lz = 1'b0;
    check_scan();

    // Hex load: immediate, no busy.
    dp_mask = 4'b0100;
    start(16'hBEEF, 1'b1);
    chk("hex_busy0", 32'(busy), 32'd0);
    step();
    chk("hex_busy1", 32'(busy), 32'd0);
    set_hex(16'hBEEF);
    chk("ovf_hex", 32'(overflow), 32'd0);
    check_scan();

    // A strobe during conversion is dropped.
    dp_mask = 4'b0000;
    start(2024, 1'b0);
    repeat (3) step();
    value = 16'h0001;
    hex_mode = 1'b1;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    wait_idle(n);
    chk("busy_len_ignore", 32'(n), 32'd12);
    set_dec(2024);
    chk("ovf_2024", 32'(overflow), 32'd0);
    check_scan();

    // Display disabled for three scans, then resumed.
    enable = 1'b0;
    repeat (3) check_scan();
    enable = 1'b1;
    check_scan();

    // Randomised values, modes and live inputs.
    repeat (8) begin
      v = int'($urandom_range(0, 65535));
      h = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      dp_mask = 4'($urandom_range(0, 15));
      if (($urandom_range(0, 3)) == 0) v = int'($urandom_range(0, 99));
      start(v, h);
      wait_idle(n);
      chk("rand_busy_len", 32'(n), h ? 32'd0 : 32'd16);
      if (h) set_hex(v);
      else set_dec(v);
      chk("rand_ovf", 32'(overflow), 32'(ovf_m));
      check_scan();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
